bist_controller: RTL and testbench

Sequencing FSM for the 1-bit full-adder BIST loop. On `start` it seeds the pattern generator (TPG), clears the MISR output-response analyser (ORA), and steps the TPG for a fixed number of patterns while the ORA compacts the adder's outputs. It then compares the 4-bit signature against a golden value and reports pass or fail. The block sits beside the TPG, the CUT input mux and the ORA, and is the only source of their enables and resets.

---
 rtl/bist_controller.sv | 67 ++++++
 tb/tb_bist_controller.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// bist_controller: sequences TPG seeding, MISR compaction and signature check for the full-adder BIST loop
module bist_controller #(
  parameter int NUM_PATTERNS = 8,
  parameter int CNT_W = 4,
  parameter logic [3:0] GOLDEN_SIG = 4'hA
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       misr_sig,
  output logic             tpg_load,
  output logic             tpg_enable,
  output logic             test_mode,
  output logic             ora_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [3:0]       signature,
  output logic [CNT_W-1:0] pattern_count
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, COMPARE, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);
  state_t state, state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? INIT : IDLE;
      INIT:    state_next = abort ? IDLE : RUN;
      RUN:     state_next = abort ? IDLE : (pattern_count == LAST) ? COMPARE : RUN;
      COMPARE: state_next = abort ? IDLE : DONE;
      DONE:    state_next = start ? INIT : DONE;
      default: state_next = IDLE;
    endcase
    tpg_load   = state == INIT;
    tpg_enable = state == RUN;
    test_mode  = state inside {INIT, RUN, COMPARE};
    ora_rst_n  = state inside {RUN, COMPARE, DONE};
    busy       = state inside {INIT, RUN, COMPARE};
    done       = state == DONE;
  end
  // Entering INIT or IDLE wipes the previous result so pass/fail never outlive done
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      pattern_count <= '0;
      signature     <= '0;
      pass          <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next inside {IDLE, INIT}) begin
        pattern_count <= '0;
        signature     <= '0;
        pass          <= 1'b0;
        fail          <= 1'b0;
      end else if (state == RUN) begin
        pattern_count <= pattern_count + 1'b1;
      end else if (state == COMPARE) begin
        signature <= misr_sig;
        pass      <= misr_sig == GOLDEN_SIG;
        fail      <= misr_sig != GOLDEN_SIG;
      end
    end
  end
endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: randomized scoreboard bench for bist_controller at NUM_PATTERNS=8 and NUM_PATTERNS=1
module tb_bist_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic [3:0] misr = 4'h0;
  logic [1:0] tpg_load, tpg_enable, test_mode, ora_rst_n, busy, done, pass, fail;
  logic [3:0] sig [2];
  logic [3:0] cnt [2];
  bist_controller #(.NUM_PATTERNS(8), .CNT_W(4), .GOLDEN_SIG(4'hA)) dut8 (
    .clock(clk), .reset(reset), .start(start & ~sel), .abort(abort), .misr_sig(misr),
    .tpg_load(tpg_load[0]), .tpg_enable(tpg_enable[0]), .test_mode(test_mode[0]),
    .ora_rst_n(ora_rst_n[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
    .signature(sig[0]), .pattern_count(cnt[0])
  );
  bist_controller #(.NUM_PATTERNS(1), .CNT_W(4), .GOLDEN_SIG(4'hA)) dut1 (
    .clock(clk), .reset(reset), .start(start & sel), .abort(abort), .misr_sig(misr),
    .tpg_load(tpg_load[1]), .tpg_enable(tpg_enable[1]), .test_mode(test_mode[1]),
    .ora_rst_n(ora_rst_n[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
    .signature(sig[1]), .pattern_count(cnt[1])
  );
  typedef struct packed {logic [3:0] sig; logic pass; logic fail; logic [3:0] cnt;} res_t;
  res_t exp_q[$];
  res_t popped;
  res_t last;
  int checks = 0, passed = 0;
  logic prev_done = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [15:0] outs();
    return {tpg_load[sel], tpg_enable[sel], test_mode[sel], ora_rst_n[sel], busy[sel],
            done[sel], pass[sel], fail[sel], sig[sel], cnt[sel]};
  endfunction
  always @(negedge clk) begin
    check("pass_fail_invariant",
          {31'd0, (pass[sel] & fail[sel]) | (~done[sel] & (pass[sel] | fail[sel]))}, 32'd0);
    if (done[sel] && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 want no result pending at %0t", $time);
      end else begin
        popped = exp_q.pop_front();
        check("result", {19'd0, sig[sel], pass[sel], fail[sel], cnt[sel]}, {19'd0, popped});
      end
    end
    prev_done <= done[sel];
  end
  task automatic run(input logic [3:0] m, input int abort_at, input int reset_at,
                     input bit hold, input bit with_abort);
    int n = sel ? 1 : 8;
    int busy_n = 0, en_n = 0, done_at = 0;
    start = 1'b1;
    abort = with_abort;
    if (abort_at == 0 && reset_at == 0) begin
      last = res_t'({m, m == 4'hA, m != 4'hA, 4'(n)});
      exp_q.push_back(last);
    end
    for (int j = 1; j <= n + 3; j++) begin
      @(negedge clk);
      start = hold && j <= n + 2;
      abort = 1'b0;
      misr = (j == n + 2) ? m : m ^ 4'($urandom_range(1, 15));
      if (j == 1) check("init_outputs", {16'd0, outs()}, {16'd0, 8'b1010_1000, 8'h00});
      if (abort_at != 0 && j == abort_at + 1) begin
        check("abort_idle", {16'd0, outs()}, 32'd0);
        return;
      end
      if (reset_at != 0 && j == reset_at + 1) begin
        check("reset_midrun", {16'd0, outs()}, 32'd0);
        reset = 1'b0;
        return;
      end
      if (j == abort_at) abort = 1'b1;
      if (j == reset_at) reset = 1'b1;
      busy_n += int'(busy[sel]);
      en_n += int'(tpg_enable[sel]);
      if (done[sel] && done_at == 0) done_at = j;
    end
    check("busy_cycles", busy_n, n + 2);
    check("enable_cycles", en_n, n);
    check("done_latency", done_at + 0, n + 3);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {16'd0, outs()}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run(4'hA, 0, 0, 0, 0);
    run(4'h5, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      misr = 4'($urandom);
    end
    check("held_result", {16'd0, outs()}, {16'd0, 6'b000101, last.pass, last.fail, last.sig, last.cnt});
    run(4'hA, 0, 0, 0, 0);
    run(4'h3, 5, 0, 0, 0);
    run(4'hA, 0, 0, 0, 1);
    run(4'hC, 0, 10, 0, 0);
    run(4'hA, 0, 0, 0, 0);
    run(4'h9, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] m = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom);
      int mode = $urandom_range(0, 3);
      run(m, mode == 1 ? $urandom_range(1, 10) : 0, 0, mode == 2, mode == 3);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    check("reset_state_n1", {16'd0, outs()}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run(4'hA, 0, 0, 1, 0);
    run(4'h5, 0, 0, 1, 0);
    run(4'h7, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) run(4'($urandom), 0, 0, i[0], 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
